lock_table: RTL and testbench

LOCK_TABLE -- requirements
Module: lock_table

---
 rtl/lock_table.sv | 116 +++++++++++
 tb/tb_lock_table.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lock_table.sv
// rtl/lock_table.sv - scoreboard of pending writers for GPRs, HI, LO and CP0 (option: LOCK_BYPASS_EN)
module lock_table (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [2:0] lockreq,
    input  logic       valid,
    input  logic [4:0] lock_rd,
    input  logic       lock_cp0,
    input  logic       lock_hi,
    input  logic       lock_lo,
    input  logic [4:0] wb_rd,
    input  logic       wb_rd_en,
    input  logic       wb_cp0_en,
    input  logic       wb_hi_en,
    input  logic       wb_lo_en,
    input  logic       flush,
    output logic       rs_allow,
    output logic       rt_allow,
    output logic [2:0] lockres,
    output logic       claim_full
);

    logic [1:0]  gpr_cnt [1:31];
    logic [1:0]  hi_cnt;
    logic [1:0]  lo_cnt;
    logic [1:0]  cp0_cnt;

    logic [31:0] gpr_clm;
    logic [31:0] gpr_rel;
    logic [31:0] gpr_free;
    logic [31:0] gpr_sat;
    logic        hi_clm, lo_clm, cp0_clm;
    logic        hi_free, lo_free, cp0_free;

    // A saturated counter refuses the claim; an empty counter ignores the release.
    function automatic logic [1:0] next_cnt(input logic [1:0] cur, input logic clm, input logic rel);
        logic c;
        logic r;
        c = clm && (cur != 2'd3);
        r = rel && (cur != 2'd0);
        if (c && !r)
            next_cnt = cur + 2'd1;
        else if (r && !c)
            next_cnt = cur - 2'd1;
        else
            next_cnt = cur;
    endfunction

    function automatic logic is_free(input logic [1:0] cur, input logic clm, input logic rel,
                                     input logic flush_now);
`ifdef LOCK_BYPASS_EN
        is_free = (cur == 2'd0) || ((cur == 2'd1) && rel && !clm && !flush_now);
`else
        is_free = (cur == 2'd0) || (clm && rel && flush_now && 1'b0);
`endif
    endfunction

    assign hi_clm  = valid && lock_hi;
    assign lo_clm  = valid && lock_lo;
    assign cp0_clm = valid && lock_cp0;

    always_comb begin
        gpr_clm  = '0;
        gpr_rel  = '0;
        gpr_free = '0;
        gpr_sat  = '0;
        gpr_free[0] = 1'b1;
        for (int i = 1; i < 32; i++) begin
            gpr_clm[i]  = valid && (lock_rd == 5'(i));
            gpr_rel[i]  = wb_rd_en && (wb_rd == 5'(i));
            gpr_free[i] = is_free(gpr_cnt[i], gpr_clm[i], gpr_rel[i], flush);
            gpr_sat[i]  = (gpr_cnt[i] == 2'd3);
        end
    end

    assign hi_free  = is_free(hi_cnt, hi_clm, wb_hi_en, flush);
    assign lo_free  = is_free(lo_cnt, lo_clm, wb_lo_en, flush);
    assign cp0_free = is_free(cp0_cnt, cp0_clm, wb_cp0_en, flush);

    assign rs_allow   = gpr_free[rs];
    assign rt_allow   = gpr_free[rt];
    assign lockres[2] = !lockreq[2] || cp0_free;
    assign lockres[1] = !lockreq[1] || hi_free;
    assign lockres[0] = !lockreq[0] || lo_free;

    // Not gated by valid: decode uses it to decide whether it may assert valid.
    assign claim_full = gpr_sat[lock_rd]
                     || (lock_cp0 && (cp0_cnt == 2'd3))
                     || (lock_hi  && (hi_cnt  == 2'd3))
                     || (lock_lo  && (lo_cnt  == 2'd3));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i < 32; i++)
                gpr_cnt[i] <= 2'd0;
            hi_cnt  <= 2'd0;
            lo_cnt  <= 2'd0;
            cp0_cnt <= 2'd0;
        end else if (flush) begin
            for (int i = 1; i < 32; i++)
                gpr_cnt[i] <= 2'd0;
            hi_cnt  <= 2'd0;
            lo_cnt  <= 2'd0;
            cp0_cnt <= 2'd0;
        end else begin
            for (int i = 1; i < 32; i++)
                gpr_cnt[i] <= next_cnt(gpr_cnt[i], gpr_clm[i], gpr_rel[i]);
            hi_cnt  <= next_cnt(hi_cnt, hi_clm, wb_hi_en);
            lo_cnt  <= next_cnt(lo_cnt, lo_clm, wb_lo_en);
            cp0_cnt <= next_cnt(cp0_cnt, cp0_clm, wb_cp0_en);
        end
    end

endmodule

// File: tb/tb_lock_table.sv
// tb/tb_lock_table.sv - directed self-checking bench for lock_table
module tb_lock_table;

    logic       clk;
    logic       resetn;
    logic [4:0] rs, rt;
    logic [2:0] lockreq;
    logic       valid;
    logic [4:0] lock_rd;
    logic       lock_cp0, lock_hi, lock_lo;
    logic [4:0] wb_rd;
    logic       wb_rd_en, wb_cp0_en, wb_hi_en, wb_lo_en;
    logic       flush;
    logic       rs_allow, rt_allow;
    logic [2:0] lockres;
    logic       claim_full;

    int n_cmp;
    int n_bad;

    lock_table dut (
        .clk(clk), .resetn(resetn), .rs(rs), .rt(rt), .lockreq(lockreq),
        .valid(valid), .lock_rd(lock_rd), .lock_cp0(lock_cp0), .lock_hi(lock_hi),
        .lock_lo(lock_lo), .wb_rd(wb_rd), .wb_rd_en(wb_rd_en), .wb_cp0_en(wb_cp0_en),
        .wb_hi_en(wb_hi_en), .wb_lo_en(wb_lo_en), .flush(flush),
        .rs_allow(rs_allow), .rt_allow(rt_allow), .lockres(lockres), .claim_full(claim_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 0; lock_rd = 0; lock_cp0 = 0; lock_hi = 0; lock_lo = 0;
        wb_rd = 0; wb_rd_en = 0; wb_cp0_en = 0; wb_hi_en = 0; wb_lo_en = 0; flush = 0;
    endtask

    task automatic test_reset();
        idle();
        resetn = 0; rs = 5; rt = 0; lockreq = 3'b111;
        #12;
        n_cmp++; if (rs_allow !== 1'b1) begin n_bad++; $display("FAIL reset_rs_allow: got %b expected 1", rs_allow); end
        n_cmp++; if (rt_allow !== 1'b1) begin n_bad++; $display("FAIL reset_rt_allow: got %b expected 1", rt_allow); end
        n_cmp++; if (lockres !== 3'b111) begin n_bad++; $display("FAIL reset_lockres: got %b expected 111", lockres); end
        n_cmp++; if (claim_full !== 1'b0) begin n_bad++; $display("FAIL reset_claim_full: got %b expected 0", claim_full); end
        @(negedge clk);
        resetn = 1;
        step();
        n_cmp++; if (rs_allow !== 1'b1 || lockres !== 3'b111) begin n_bad++; $display("FAIL after_reset: got rs_allow=%b lockres=%b expected 1/111", rs_allow, lockres); end
    endtask

    task automatic test_claim_release();
        idle(); rs = 8;
        valid = 1; lock_rd = 8;
        #1;
        n_cmp++; if (rs_allow !== 1'b1) begin n_bad++; $display("FAIL r8_cycle_n: got %b expected 1", rs_allow); end
        step(); idle();
        n_cmp++; if (rs_allow !== 1'b0) begin n_bad++; $display("FAIL r8_n1: got %b expected 0", rs_allow); end
        step();
        n_cmp++; if (rs_allow !== 1'b0) begin n_bad++; $display("FAIL r8_n2: got %b expected 0", rs_allow); end
        step();
        wb_rd = 8; wb_rd_en = 1;
        #1;
`ifdef LOCK_BYPASS_EN
        n_cmp++; if (rs_allow !== 1'b1) begin n_bad++; $display("FAIL r8_n3_bypass: got %b expected 1", rs_allow); end
`else
        n_cmp++; if (rs_allow !== 1'b0) begin n_bad++; $display("FAIL r8_n3: got %b expected 0", rs_allow); end
`endif
        step(); idle();
        n_cmp++; if (rs_allow !== 1'b1) begin n_bad++; $display("FAIL r8_n4: got %b expected 1", rs_allow); end
    endtask

    task automatic release_r9();
        wb_rd = 9; wb_rd_en = 1;
        step();
        wb_rd_en = 0;
        #1;
    endtask

    task automatic test_saturate();
        idle(); rt = 9;
        valid = 1; lock_rd = 9;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (claim_full !== 1'b0) begin n_bad++; $display("FAIL sat_claim_%0d: got claim_full=%b expected 0", k, claim_full); end
            step();
        end
        n_cmp++; if (claim_full !== 1'b1) begin n_bad++; $display("FAIL sat_fourth: got claim_full=%b expected 1", claim_full); end
        step();
        valid = 0;
        #1;
        n_cmp++; if (claim_full !== 1'b1) begin n_bad++; $display("FAIL sat_stays3: got claim_full=%b expected 1", claim_full); end
        release_r9();
        n_cmp++; if (claim_full !== 1'b0 || rt_allow !== 1'b0) begin n_bad++; $display("FAIL sat_rel1: got claim_full=%b rt_allow=%b expected 0/0", claim_full, rt_allow); end
        release_r9();
        n_cmp++; if (rt_allow !== 1'b0) begin n_bad++; $display("FAIL sat_rel2: got rt_allow=%b expected 0", rt_allow); end
        release_r9();
        n_cmp++; if (rt_allow !== 1'b1) begin n_bad++; $display("FAIL sat_rel3: got rt_allow=%b expected 1", rt_allow); end
        idle();
    endtask

    task automatic test_same_cycle();
        idle(); rs = 4;
        valid = 1; lock_rd = 4;
        step();
        wb_rd = 4; wb_rd_en = 1;
        #1;
        n_cmp++; if (rs_allow !== 1'b0) begin n_bad++; $display("FAIL r4_both_comb: got %b expected 0", rs_allow); end
        step(); idle();
        n_cmp++; if (rs_allow !== 1'b0) begin n_bad++; $display("FAIL r4_both_next: got %b expected 0", rs_allow); end
        wb_rd = 4; wb_rd_en = 1;
        step(); idle();
        n_cmp++; if (rs_allow !== 1'b1) begin n_bad++; $display("FAIL r4_release: got %b expected 1", rs_allow); end
    endtask

    task automatic test_hilo();
        idle();
        valid = 1; lock_hi = 1; lock_lo = 1;
        step(); idle();
        lockreq = 3'b011;
        #1;
        n_cmp++; if (lockres !== 3'b100) begin n_bad++; $display("FAIL hilo_claimed: got %b expected 100", lockres); end
        wb_hi_en = 1;
        step(); idle();
        n_cmp++; if (lockres !== 3'b110) begin n_bad++; $display("FAIL hi_released: got %b expected 110", lockres); end
        lockreq = 3'b111; wb_lo_en = 1;
        step(); idle();
        n_cmp++; if (lockres !== 3'b111) begin n_bad++; $display("FAIL lo_released: got %b expected 111", lockres); end
    endtask

    task automatic test_distinct();
        idle();
        valid = 1; lock_rd = 6;
        step();
        lock_rd = 5; lock_hi = 1; wb_rd = 6; wb_rd_en = 1;
        step(); idle();
        rs = 5; rt = 6; lockreq = 3'b010;
        #1;
        n_cmp++; if (rs_allow !== 1'b0 || rt_allow !== 1'b1) begin n_bad++; $display("FAIL distinct_gpr: got rs_allow=%b rt_allow=%b expected 0/1", rs_allow, rt_allow); end
        n_cmp++; if (lockres !== 3'b101) begin n_bad++; $display("FAIL distinct_hi: got %b expected 101", lockres); end
    endtask

    task automatic test_flush();
        idle();
        flush = 1;
        step(); idle();
        valid = 1; lock_rd = 3; lock_cp0 = 1;
        step(); idle();
        rs = 3; lockreq = 3'b100;
        #1;
        n_cmp++; if (rs_allow !== 1'b0 || lockres !== 3'b011) begin n_bad++; $display("FAIL pre_flush: got rs_allow=%b lockres=%b expected 0/011", rs_allow, lockres); end
        flush = 1; valid = 1; lock_rd = 7;
        step(); idle();
        rt = 7; lockreq = 3'b111;
        #1;
        n_cmp++; if (rs_allow !== 1'b1 || rt_allow !== 1'b1) begin n_bad++; $display("FAIL post_flush_allow: got rs=%b rt=%b expected 1/1", rs_allow, rt_allow); end
        n_cmp++; if (lockres !== 3'b111) begin n_bad++; $display("FAIL post_flush_lockres: got %b expected 111", lockres); end
    endtask

    task automatic test_r0();
        idle();
        valid = 1; lock_rd = 0;
        step();
        #1;
        n_cmp++; if (claim_full !== 1'b0) begin n_bad++; $display("FAIL r0_claim_full: got %b expected 0", claim_full); end
        idle(); rs = 0;
        n_cmp++; if (rs_allow !== 1'b1) begin n_bad++; $display("FAIL r0_allow: got %b expected 1", rs_allow); end
    endtask

    task automatic test_async_reset();
        idle(); rs = 10;
        valid = 1; lock_rd = 10;
        step(); idle();
        n_cmp++; if (rs_allow !== 1'b0) begin n_bad++; $display("FAIL r10_claimed: got %b expected 0", rs_allow); end
        #1 resetn = 0;
        #1;
        n_cmp++; if (rs_allow !== 1'b1) begin n_bad++; $display("FAIL async_reset: got %b expected 1", rs_allow); end
        @(negedge clk);
        resetn = 1;
        step();
        n_cmp++; if (rs_allow !== 1'b1) begin n_bad++; $display("FAIL after_async_reset: got %b expected 1", rs_allow); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_claim_release();
        test_saturate();
        test_same_cycle();
        test_hilo();
        test_distinct();
        test_flush();
        test_r0();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
